// File: rtl/img_dma_pkg.sv
// Shared definitions for the image memory-to-stream reader.
// CSR offsets, CTRL/STATUS bit indices, length width and FSM states.
package img_dma_pkg;

  localparam logic [1:0] CSR_START  = 2'd0;
  localparam logic [1:0] CSR_LEN    = 2'd1;
  localparam logic [1:0] CSR_CTRL   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  localparam int LEN_W = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } dma_state_e;

endpackage

// File: rtl/img_stream_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and flush.
// Ports: i_push/i_data in, i_pop out-side, o_data/o_empty/o_count status.
module img_stream_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && !i_flush;
  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/img_mem_stream_reader.sv
// Reads a run of pixel words from image RAM and emits an Avalon-ST packet.
// Ports: Avalon-MM CSR slave, RAM read port, Avalon-ST source, irq.
module img_mem_stream_reader
  import img_dma_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int MEM_WORDS  = 10000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_start, r_rd_addr;
  logic [LEN_W-1:0]  r_len, r_issue_cnt, r_beat_cnt;
  logic              r_irq_en, r_done, r_inflight, r_sop;
  logic [31:0]       r_readdata, w_rdata, w_fifo_data;
  logic              w_wr_start, w_wr_len, w_wr_ctrl, w_wr_stat;
  logic              w_go, w_abort, w_issue, w_fire, w_last_beat;
  logic              w_set_done, w_launch, w_busy, w_empty;
  logic [CW-1:0]     w_fifo_count;
  logic [CW:0]       w_occ;
  logic              w_unused;

  assign w_unused   = ^csr_writedata[31:LEN_W];
  assign w_busy     = (r_state != IDLE);
  assign w_wr_start = csr_write && (csr_address == CSR_START) && !w_busy;
  assign w_wr_len   = csr_write && (csr_address == CSR_LEN) && !w_busy;
  assign w_wr_ctrl  = csr_write && (csr_address == CSR_CTRL);
  assign w_wr_stat  = csr_write && (csr_address == CSR_STATUS);
  assign w_abort    = w_wr_ctrl && csr_writedata[CTRL_ABORT];
  assign w_go       = w_wr_ctrl && csr_writedata[CTRL_GO]
                      && !w_busy && !w_abort;

  // Count the read in flight so the FIFO can never overflow.
  assign w_occ   = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue = (r_state == RUN) && (r_issue_cnt != '0)
                   && (w_occ < (CW+1)'(FIFO_DEPTH)) && !w_abort;

  assign w_fire      = !w_empty && src_ready;
  assign w_last_beat = w_fire && (r_beat_cnt == LEN_W'(1));

  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_launch   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          if (r_len != '0) begin
            w_next   = RUN;
            w_launch = 1'b1;
          end else begin
            w_set_done = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_issue && (r_issue_cnt == LEN_W'(1))) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_last_beat || (r_beat_cnt == '0)) begin
          w_next     = IDLE;
          w_set_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) begin
      w_next     = IDLE;
      w_set_done = 1'b0;
      w_launch   = 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (csr_address)
      CSR_START:  w_rdata[ADDR_W-1:0] = r_start;
      CSR_LEN:    w_rdata[LEN_W-1:0]  = r_len;
      CSR_CTRL:   w_rdata[CTRL_IRQ_EN] = r_irq_en;
      CSR_STATUS: begin
        w_rdata[STAT_BUSY] = w_busy;
        w_rdata[STAT_DONE] = r_done;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_start     <= '0;
      r_len       <= '0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_rd_addr   <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_sop       <= 1'b0;
      r_readdata  <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_wr_start) r_start <= csr_writedata[ADDR_W-1:0];
      if (w_wr_len)   r_len   <= csr_writedata[LEN_W-1:0];
      if (w_wr_ctrl)  r_irq_en <= csr_writedata[CTRL_IRQ_EN];
      if (w_set_done) r_done <= 1'b1;
      else if (w_wr_stat && csr_writedata[STAT_DONE]) r_done <= 1'b0;
      if (csr_read) r_readdata <= w_rdata;
      if (w_launch) begin
        r_rd_addr   <= r_start;
        r_issue_cnt <= r_len;
        r_beat_cnt  <= r_len;
        r_sop       <= 1'b1;
      end else begin
        if (w_issue) begin
          r_rd_addr <= (r_rd_addr == ADDR_W'(MEM_WORDS - 1))
                       ? '0 : r_rd_addr + ADDR_W'(1);
          r_issue_cnt <= r_issue_cnt - LEN_W'(1);
        end
        if (w_fire) begin
          r_beat_cnt <= r_beat_cnt - LEN_W'(1);
          r_sop      <= 1'b0;
        end
      end
    end
  end

  // Returned word lands in the FIFO the cycle after issue; abort flushes it.
  img_stream_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_abort),
    .i_push  (r_inflight),
    .i_data  (mem_readdata),
    .i_pop   (src_ready),
    .o_data  (w_fifo_data),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign csr_readdata      = r_readdata;
  assign mem_address       = r_rd_addr;
  assign mem_chipselect    = w_issue;
  assign mem_clken         = w_issue;
  assign src_valid         = !w_empty;
  assign src_data          = w_empty ? '0 : w_fifo_data;
  assign src_startofpacket = !w_empty && r_sop;
  assign src_endofpacket   = !w_empty && (r_beat_cnt == LEN_W'(1));
  assign irq               = r_done && r_irq_en;

endmodule

// File: tb/tb_img_mem_stream_reader.sv
// Directed bench for img_mem_stream_reader with RAM model and beat scoreboard.
// Expected read addresses and beats are queued when a transfer is launched.
module tb_img_mem_stream_reader;
  import img_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic [13:0] mem_address;
  logic        mem_chipselect, mem_clken;
  logic [31:0] mem_readdata = '0;
  logic [31:0] src_data;
  logic        src_valid, src_ready;
  logic        src_startofpacket, src_endofpacket, irq;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [13:0] addr_q[$];
  beat_t       mon_b;
  logic [13:0] mon_a;
  int          n_chk = 0;
  int          n_pass = 0;
  int          occ = 0;
  bit          tog = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  img_mem_stream_reader dut (
    .clk               (clk),
    .reset             (reset),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_readdata      (csr_readdata),
    .mem_address       (mem_address),
    .mem_chipselect    (mem_chipselect),
    .mem_clken         (mem_clken),
    .mem_readdata      (mem_readdata),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_startofpacket (src_startofpacket),
    .src_endofpacket   (src_endofpacket),
    .irq               (irq)
  );

  function automatic logic [31:0] pix(input logic [13:0] a);
    return {4'hA, a, ~a};
  endfunction

  always @(posedge clk)
    if (mem_clken && mem_chipselect) mem_readdata <= pix(mem_address);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      if (mem_clken) begin
        chk("read_room", 32'(occ < 4), 1);
        chk("read_expected", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) begin
          mon_a = addr_q.pop_front();
          chk("read_addr", 32'(mem_address), 32'(mon_a));
        end
        occ++;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(src_valid), 1);
        chk("stall_data", src_data, prev_data);
      end
      if (src_valid && src_ready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_b = exp_q.pop_front();
          chk("beat_data", src_data, mon_b.d);
          chk("beat_sop", 32'(src_startofpacket), 32'(mon_b.sop));
          chk("beat_eop", 32'(src_endofpacket), 32'(mon_b.eop));
        end
        occ--;
      end
      prev_stall = src_valid && !src_ready;
      prev_data  = src_data;
      if (csr_write && csr_address == CSR_CTRL
          && csr_writedata[CTRL_ABORT]) begin
        exp_q.delete();
        addr_q.delete();
        occ = 0;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) src_ready = !src_ready;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_write = 1'b1;
    csr_address = a;
    csr_writedata = d;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_read = 1'b1;
    csr_address = a;
    step();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic push_xfer(input int start, input int len);
    for (int i = 0; i < len; i++) begin
      logic [13:0] a;
      a = 14'((start + i) % 10000);
      addr_q.push_back(a);
      exp_q.push_back('{d: pix(a), sop: (i == 0), eop: (i == len - 1)});
    end
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int i;
    i = 0;
    while (!irq && i < budget) begin
      step();
      i++;
    end
    chk(tag, 32'(irq), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int first_rd, first_v, last_v, first_irq, nbeats, nclk, nv, nb;
    reset = 1'b1;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;
    src_ready = 1'b1;
    #13;
    chk("rst_valid", 32'(src_valid), 0);
    chk("rst_clken", 32'(mem_clken), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_readdata", csr_readdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    csr_rd(CSR_STATUS, v);
    chk("status_after_reset", v, 0);

    // Basic 8-word transfer with timing
    csr_wr(CSR_START, 32'h10);
    csr_wr(CSR_LEN, 8);
    push_xfer(16, 8);
    csr_wr(CSR_CTRL, 32'h3);
    first_rd = -1; first_v = -1; last_v = -1; first_irq = -1; nbeats = 0;
    for (int k = 1; k <= 14; k++) begin
      if (mem_clken && first_rd < 0) first_rd = k;
      if (src_valid && first_v < 0) first_v = k;
      if (src_valid) begin
        last_v = k;
        nbeats++;
      end
      if (irq && first_irq < 0) first_irq = k;
      step();
    end
    chk("first_read_cycle", 32'(first_rd), 1);
    chk("first_valid_cycle", 32'(first_v), 3);
    chk("last_valid_cycle", 32'(last_v), 10);
    chk("beat_count", 32'(nbeats), 8);
    chk("done_cycle", 32'(first_irq), 11);
    chk("queue_empty_1", 32'(exp_q.size()), 0);
    csr_rd(CSR_STATUS, v);
    chk("status_done", v, 32'h2);
    csr_rd(CSR_CTRL, v);
    chk("ctrl_readback", v, 32'h2);
    csr_wr(CSR_STATUS, 32'h2);
    chk("irq_cleared", 32'(irq), 0);
    csr_rd(CSR_STATUS, v);
    chk("status_cleared", v, 0);

    // Address wrap
    csr_wr(CSR_START, 9998);
    csr_wr(CSR_LEN, 4);
    push_xfer(9998, 4);
    csr_wr(CSR_CTRL, 32'h3);
    wait_irq(40, "done_wrap");
    chk("queue_empty_wrap", 32'(exp_q.size()), 0);
    chk("addr_q_empty_wrap", 32'(addr_q.size()), 0);
    csr_wr(CSR_STATUS, 32'h2);

    // Backpressure toggling every cycle
    csr_wr(CSR_START, 100);
    csr_wr(CSR_LEN, 6);
    push_xfer(100, 6);
    tog = 1'b1;
    csr_wr(CSR_CTRL, 32'h3);
    wait_irq(80, "done_stall");
    tog = 1'b0;
    src_ready = 1'b1;
    chk("queue_empty_stall", 32'(exp_q.size()), 0);
    csr_wr(CSR_STATUS, 32'h2);

    // Zero length
    csr_wr(CSR_LEN, 0);
    csr_wr(CSR_CTRL, 32'h3);
    chk("len0_done", 32'(irq), 1);
    nclk = 0; nv = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_clken) nclk++;
      if (src_valid) nv++;
      step();
    end
    chk("len0_reads", 32'(nclk), 0);
    chk("len0_beats", 32'(nv), 0);
    csr_wr(CSR_STATUS, 32'h2);

    // GO/START/LEN while busy are ignored
    csr_wr(CSR_START, 200);
    csr_wr(CSR_LEN, 10);
    push_xfer(200, 10);
    csr_wr(CSR_CTRL, 32'h3);
    step(); step(); step();
    csr_wr(CSR_START, 500);
    csr_wr(CSR_LEN, 3);
    csr_wr(CSR_CTRL, 32'h3);
    wait_irq(60, "done_busy_go");
    chk("queue_empty_busy", 32'(exp_q.size()), 0);
    csr_rd(CSR_START, v);
    chk("start_kept", v, 200);
    csr_rd(CSR_LEN, v);
    chk("len_kept", v, 10);
    csr_wr(CSR_STATUS, 32'h2);

    // Abort after five beats, then restart
    csr_wr(CSR_START, 300);
    csr_wr(CSR_LEN, 20);
    push_xfer(300, 20);
    csr_wr(CSR_CTRL, 32'h3);
    nb = 0;
    for (int k = 0; k < 40 && nb < 5; k++) begin
      if (src_valid && src_ready) nb++;
      step();
    end
    chk("abort_beats_seen", 32'(nb), 5);
    csr_wr(CSR_CTRL, 32'h6);
    chk("abort_valid", 32'(src_valid), 0);
    chk("abort_irq", 32'(irq), 0);
    csr_rd(CSR_STATUS, v);
    chk("abort_status", v, 0);
    csr_wr(CSR_START, 40);
    csr_wr(CSR_LEN, 3);
    push_xfer(40, 3);
    csr_wr(CSR_CTRL, 32'h3);
    wait_irq(40, "done_restart");
    chk("queue_empty_restart", 32'(exp_q.size()), 0);
    csr_wr(CSR_STATUS, 32'h2);

    // Asynchronous reset mid-transfer
    csr_wr(CSR_START, 0);
    csr_wr(CSR_LEN, 20);
    push_xfer(0, 20);
    csr_wr(CSR_CTRL, 32'h3);
    step(); step(); step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(src_valid), 0);
    chk("arst_sop", 32'(src_startofpacket), 0);
    chk("arst_eop", 32'(src_endofpacket), 0);
    chk("arst_data", src_data, 0);
    chk("arst_clken", 32'(mem_clken), 0);
    chk("arst_cs", 32'(mem_chipselect), 0);
    chk("arst_addr", 32'(mem_address), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_readdata", csr_readdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    csr_rd(CSR_STATUS, v);
    chk("arst_status", v, 0);
    csr_rd(CSR_CTRL, v);
    chk("arst_ctrl", v, 0);
    csr_wr(CSR_CTRL, 32'h2);
    csr_wr(CSR_LEN, 0);
    csr_wr(CSR_CTRL, 32'h3);
    chk("w1c_irq_set", 32'(irq), 1);
    csr_wr(CSR_STATUS, 32'h2);
    chk("w1c_irq_drop", 32'(irq), 0);
    csr_rd(CSR_STATUS, v);
    chk("w1c_status", v, 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
